// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo buffer: drain FSM states,
// byte width and the ASCII lower-case bounds used by the optional upper-case mapping.
package uart_echo_pkg;

   localparam int unsigned BYTE_W = 8;

   localparam logic [BYTE_W-1:0] ASCII_LC_LO    = 8'h61;
   localparam logic [BYTE_W-1:0] ASCII_LC_HI    = 8'h7A;
   localparam logic [BYTE_W-1:0] ASCII_CASE_OFS = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LAUNCH    = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } drain_state_e;

   function automatic logic [BYTE_W-1:0] to_upper(input logic [BYTE_W-1:0] b);
      logic [BYTE_W-1:0] r;
      if ((b >= ASCII_LC_LO) && (b <= ASCII_LC_HI)) begin
         r = b - ASCII_CASE_OFS;
      end else begin
         r = b;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_echo_fifo_byte_fifo.sv
// Synchronous DEPTH x 8 FIFO with registered occupancy count.
// Full/empty come from the count at the start of the cycle, so a push on full is refused.
module byte_fifo
   import uart_echo_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [BYTE_W-1:0]        wdata_i,
   input  logic                     pop_i,
   output logic [BYTE_W-1:0]        rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              do_push_s, do_pop_s;

   assign full_o    = (count_q == CW'(DEPTH));
   assign empty_o   = (count_q == {CW{1'b0}});
   assign do_push_s = push_i & ~full_o;
   assign do_pop_s  = pop_i & ~empty_o;
   assign rdata_o   = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   // Next-state for pointers and occupancy; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage array; contents are don't-care after reset since pointers clear.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/uart_echo_fifo.sv
// UART echo elastic buffer: queues received bytes and drains them into the transmitter
// via tx_en/tx_busy, keeping a 4-byte display history. Option: ECHO_UPPERCASE_EN.
module uart_echo_fifo
   import uart_echo_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int BUSY_WAIT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [BYTE_W-1:0]        rx_data_i,
   input  logic                     rx_valid_i,
   output logic [BYTE_W-1:0]        tx_data_o,
   output logic                     tx_en_o,
   input  logic                     tx_busy_i,
   output logic [31:0]              disp_value_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_o,
   input  logic                     clr_overflow_i
);

   localparam int WW = $clog2(BUSY_WAIT + 1);

   drain_state_e      state_q;
   logic [WW-1:0]     wait_cnt_q;
   logic [BYTE_W-1:0] tx_data_q;
   logic              tx_en_q;
   logic [31:0]       disp_q;
   logic              overflow_q;
   logic              pop_s;
   logic [BYTE_W-1:0] head_s;
   logic [BYTE_W-1:0] tx_load_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rx_valid_i),
      .wdata_i (rx_data_i),
      .pop_i   (pop_s),
      .rdata_o (head_s),
      .full_o  (fifo_full_s),
      .empty_o (fifo_empty_s),
      .count_o (count_o)
   );

   // Pop the head only when idle, something is queued and the transmitter is free.
   always_comb begin
      pop_s = 1'b0;
      if ((state_q == ST_IDLE) && !fifo_empty_s && !tx_busy_i) begin
         pop_s = 1'b1;
      end else begin
         pop_s = 1'b0;
      end
`ifdef ECHO_UPPERCASE_EN
      tx_load_s = to_upper(head_s);
`else
      tx_load_s = head_s;
`endif
   end

   // Drain FSM; tx_en is registered so it is high exactly during LAUNCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= {WW{1'b0}};
         tx_data_q  <= {BYTE_W{1'b0}};
         tx_en_q    <= 1'b0;
      end else begin
         tx_en_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pop_s) begin
                  tx_data_q <= tx_load_s;
                  tx_en_q   <= 1'b1;
                  state_q   <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               wait_cnt_q <= {WW{1'b0}};
               state_q    <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (tx_busy_i) begin
                  state_q <= ST_WAIT_DONE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WW'(1);
                  if ((wait_cnt_q + WW'(1)) == WW'(BUSY_WAIT)) begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy_i) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Display history and sticky overflow; a drop in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q     <= 32'h0000_0000;
         overflow_q <= 1'b0;
      end else begin
         if (rx_valid_i) begin
            disp_q <= {disp_q[23:0], rx_data_i};
         end
         if (rx_valid_i && fifo_full_s) begin
            overflow_q <= 1'b1;
         end else if (clr_overflow_i) begin
            overflow_q <= 1'b0;
         end
      end
   end

   assign tx_data_o    = tx_data_q;
   assign tx_en_o      = tx_en_q;
   assign disp_value_o = disp_q;
   assign overflow_o   = overflow_q;

endmodule
